// File: rtl/expr_operand_sequencer_pkg.sv
// Shared types, sizes and operand field geometry for the expression operand sequencer.
package expr_seq_pkg;

    localparam int Y_W   = 90;
    localparam int OPS_W = 60;
    localparam int N_OPS = 12;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_EVAL  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // Field widths repeat 4,5,6 for a0..a5 then b0..b5.
    function automatic int W(input int k);
        return 4 + (k % 3);
    endfunction

    // LSB position of field k in core_ops; field 0 sits at the MSB end.
    function automatic int OFF(input int k);
        int prefix;
        prefix = 15 * (k / 3) + ((k % 3 == 0) ? 0 : ((k % 3 == 1) ? 4 : 9));
        return OPS_W - prefix - W(k);
    endfunction

endpackage

// File: rtl/expr_operand_sequencer_if.sv
// Operand stream, core and result stream bundle; slave is the sequencer side.
interface expr_seq_if #(
    parameter int OUT_W = 18
);
    logic                              in_valid;
    logic                              in_ready;
    logic [5:0]                        in_data;
    logic                              in_last;
    logic [expr_seq_pkg::OPS_W-1:0]    core_ops;
    logic                              core_launch;
    logic [expr_seq_pkg::Y_W-1:0]      core_y;
    logic                              out_valid;
    logic                              out_ready;
    logic [OUT_W-1:0]                  out_data;
    logic                              out_last;
    logic [3:0]                        out_tag;
    logic                              busy;
    logic                              err_frame;

    modport slave (
        input  in_valid, in_data, in_last, core_y, out_ready,
        output in_ready, core_ops, core_launch, out_valid, out_data,
               out_last, out_tag, busy, err_frame
    );

    modport master (
        output in_valid, in_data, in_last, core_y, out_ready,
        input  in_ready, core_ops, core_launch, out_valid, out_data,
               out_last, out_tag, busy, err_frame
    );
endinterface

// File: rtl/expr_seq_unpacker.sv
// Beat index, operand field capture and short-frame detection.
module expr_seq_unpacker
    import expr_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_en_i,
    input  logic             in_valid_i,
    input  logic [5:0]       in_data_i,
    input  logic             in_last_i,
    output logic [OPS_W-1:0] ops_o,
    output logic             frame_done_o,
    output logic             err_frame_o
);

    logic [3:0]       k_q;
    logic [OPS_W-1:0] ops_q;
    logic [OPS_W-1:0] ops_d;
    logic             err_q;
    logic             accept;
    logic             at_end;

    assign accept       = load_en_i && in_valid_i;
    assign at_end       = (k_q == 4'(N_OPS - 1));
    assign frame_done_o = accept && at_end;
    assign ops_o        = ops_q;
    assign err_frame_o  = err_q;

    // Only the low W(k) bits of a beat land in its field; upper bits are dropped.
    generate
        for (genvar gi = 0; gi < N_OPS; gi++) begin : g_field
            localparam int FW = W(gi);
            localparam int FO = OFF(gi);
            assign ops_d[FO +: FW] = (accept && k_q == 4'(gi)) ? in_data_i[FW-1:0]
                                                               : ops_q[FO +: FW];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q   <= '0;
            ops_q <= '0;
            err_q <= 1'b0;
        end else begin
            ops_q <= ops_d;
            err_q <= accept && in_last_i && !at_end;
            if (accept) begin
                k_q <= (at_end || in_last_i) ? 4'd0 : k_q + 4'd1;
            end
        end
    end

endmodule

// File: rtl/expr_operand_sequencer.sv
// Collects twelve operands, waits for the expression core, then streams its result out.
module expr_operand_sequencer
    import expr_seq_pkg::*;
#(
    parameter int OUT_W       = 18,
    parameter int EVAL_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    expr_seq_if.slave  bus
);

    localparam int         N_CHUNK    = Y_W / OUT_W;
    localparam logic [3:0] EVAL_LAST  = 4'(EVAL_CYCLES - 1);
    localparam logic [3:0] CHUNK_LAST = 4'(N_CHUNK - 1);
    localparam logic [3:0] CHUNK_PEN  = 4'(N_CHUNK - 2);

    state_e           state_q;
    logic             run_q;
    logic [3:0]       cnt_q;
    logic [3:0]       chunk_q;
    logic [Y_W-1:0]   res_q;
    logic [3:0]       tag_q;
    logic             launch_q;
    logic             last_q;
    logic             busy_q;
    logic             load_en;
    logic             frame_done;
    logic             out_hs;
    logic [OPS_W-1:0] ops;
    logic             err_frame;

    // run_q keeps in_ready low until the first edge after reset release.
    assign load_en       = run_q && (state_q == ST_LOAD);
    assign bus.in_ready  = load_en;
    assign bus.out_valid = (state_q == ST_DRAIN);
    assign out_hs        = bus.out_valid && bus.out_ready;

    assign bus.core_ops    = ops;
    assign bus.core_launch = launch_q;
    assign bus.out_data    = res_q[Y_W-1 -: OUT_W];
    assign bus.out_last    = last_q;
    assign bus.out_tag     = tag_q;
    assign bus.busy        = busy_q;
    assign bus.err_frame   = err_frame;

    expr_seq_unpacker u_unpacker (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_en_i    (load_en),
        .in_valid_i   (bus.in_valid),
        .in_data_i    (bus.in_data),
        .in_last_i    (bus.in_last),
        .ops_o        (ops),
        .frame_done_o (frame_done),
        .err_frame_o  (err_frame)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_LOAD;
            run_q    <= 1'b0;
            cnt_q    <= '0;
            chunk_q  <= '0;
            res_q    <= '0;
            tag_q    <= '0;
            launch_q <= 1'b0;
            last_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            run_q    <= 1'b1;
            launch_q <= 1'b0;
            case (state_q)
                ST_LOAD: begin
                    if (frame_done) begin
                        state_q  <= ST_EVAL;
                        launch_q <= 1'b1;
                        busy_q   <= 1'b1;
                        cnt_q    <= '0;
                    end
                end
                ST_EVAL: begin
                    if (cnt_q == EVAL_LAST) begin
                        state_q <= ST_DRAIN;
                        res_q   <= bus.core_y;
                        chunk_q <= '0;
                        last_q  <= (N_CHUNK == 1);
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                ST_DRAIN: begin
                    if (out_hs) begin
                        res_q <= res_q << OUT_W;
                        if (chunk_q == CHUNK_LAST) begin
                            state_q <= ST_LOAD;
                            busy_q  <= 1'b0;
                            last_q  <= 1'b0;
                            chunk_q <= '0;
                            tag_q   <= tag_q + 4'd1;
                        end else begin
                            chunk_q <= chunk_q + 4'd1;
                            last_q  <= (chunk_q == CHUNK_PEN);
                        end
                    end
                end
                default: state_q <= ST_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_expr_operand_sequencer.sv
// Directed bench for expr_operand_sequencer with OUT_W=18, EVAL_CYCLES=3.
module tb_expr_operand_sequencer;

    localparam int OUT_W = 18;
    localparam int EVAL  = 3;
    localparam int NCH   = 90 / OUT_W;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    int   launch_cnt;
    int   err_cnt;

    expr_seq_if #(.OUT_W(OUT_W)) bus ();

    expr_operand_sequencer #(.OUT_W(OUT_W), .EVAL_CYCLES(EVAL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.core_launch) launch_cnt <= launch_cnt + 1;
        if (bus.err_frame)   err_cnt    <= err_cnt + 1;
    end

    task automatic check(input string tag, input logic [89:0] got, input logic [89:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [5:0] d, input logic l);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        while (!bus.in_ready && n < 200) begin
            step();
            n++;
        end
        if (!bus.in_ready) check("beat_timeout", 90'(bus.in_ready), 90'(1));
        step();
        $display("beat data=%0h last=%0b", d, l);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic drain_all(input logic [89:0] y, input logic [3:0] tag);
        int n;
        bus.out_ready = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            n = 0;
            while (!bus.out_valid && n < 200) begin
                step();
                n++;
            end
            check("out_valid", 90'(bus.out_valid), 90'(1));
            check("out_data", 90'(bus.out_data), 90'(y[89 - i*OUT_W -: OUT_W]));
            check("out_last", 90'(bus.out_last), 90'(i == NCH - 1));
            check("out_tag", 90'(bus.out_tag), 90'(tag));
            $display("chunk %0d data=%0h last=%0b tag=%0d", i, bus.out_data, bus.out_last, bus.out_tag);
            step();
        end
        bus.out_ready = 1'b0;
    endtask

    logic [89:0] y1, y2, y3, ych;
    logic [59:0] exp_ops;
    int          idx;
    int          n;
    logic        ph;

    initial begin
        clk = 1'b0;
        rst_n = 1'b0;
        n_checks = 0;
        n_errors = 0;
        launch_cnt = 0;
        err_cnt = 0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.in_last = 1'b0;
        bus.out_ready = 1'b0;
        bus.core_y = '0;
        y1 = {18'd1, 18'd2, 18'd3, 18'd4, 18'd5};
        y2 = {18'h3FFFF, 18'h00000, 18'h2AAAA, 18'h15555, 18'h12345};
        y3 = 90'hDEADBEEF0123456789ABCD;

        // Reset state
        #12;
        check("rst_in_ready", 90'(bus.in_ready), 90'(0));
        check("rst_outs", 90'({bus.out_valid, bus.out_data, bus.out_last, bus.out_tag,
                               bus.busy, bus.err_frame, bus.core_launch}), 90'(0));
        check("rst_core_ops", 90'(bus.core_ops), 90'(0));
        @(negedge clk);
        rst_n = 1'b1;
        check("ready_pre_edge", 90'(bus.in_ready), 90'(0));
        step();
        check("ready_after_edge", 90'(bus.in_ready), 90'(1));

        // Frame 1: all-ones beats, latency and in-order drain
        bus.core_y = y1;
        for (int k = 0; k < 12; k++) send_beat(6'h3F, 1'b0);
        check("ops_all_ones", 90'(bus.core_ops), 90'(60'hFFF_FFFF_FFFF_FFFF));
        check("launch_high", 90'(bus.core_launch), 90'(1));
        check("busy_eval", 90'(bus.busy), 90'(1));
        check("ready_eval", 90'(bus.in_ready), 90'(0));
        check("valid_t1", 90'(bus.out_valid), 90'(0));
        step();
        check("launch_low", 90'(bus.core_launch), 90'(0));
        step();
        check("valid_t3", 90'(bus.out_valid), 90'(0));
        step();
        check("valid_t4", 90'(bus.out_valid), 90'(1));
        drain_all(y1, 4'd0);
        check("ready_after_drain", 90'(bus.in_ready), 90'(1));
        check("busy_after_drain", 90'(bus.busy), 90'(0));
        check("valid_after_drain", 90'(bus.out_valid), 90'(0));
        check("tag_after_1", 90'(bus.out_tag), 90'(1));
        check("launch_count_1", 90'(launch_cnt), 90'(1));

        // Frame 2: beats 1..12, out_ready toggled each cycle
        bus.core_y = y2;
        for (int k = 0; k < 12; k++) send_beat(6'(k + 1), 1'b0);
        exp_ops = {4'd1, 5'd2, 6'd3, 4'd4, 5'd5, 6'd6, 4'd7, 5'd8, 6'd9, 4'd10, 5'd11, 6'd12};
        check("ops_seq", 90'(bus.core_ops), 90'(exp_ops));
        idx = 0;
        ph = 1'b0;
        n = 0;
        while (idx < NCH && n < 100) begin
            bus.out_ready = ph;
            if (bus.out_valid) begin
                ych = y2 << (idx * OUT_W);
                check("toggle_in_ready", 90'(bus.in_ready), 90'(0));
                check("toggle_data", 90'(bus.out_data), 90'(ych[89 -: OUT_W]));
                if (ph) begin
                    check("toggle_last", 90'(bus.out_last), 90'(idx == NCH - 1));
                    check("toggle_tag", 90'(bus.out_tag), 90'(1));
                    $display("chunk %0d data=%0h last=%0b tag=%0d", idx, bus.out_data, bus.out_last, bus.out_tag);
                    idx++;
                end
            end
            ph = !ph;
            step();
            n++;
        end
        bus.out_ready = 1'b0;
        check("toggle_chunks", 90'(idx), 90'(NCH));
        check("ready_after_toggle", 90'(bus.in_ready), 90'(1));
        check("tag_after_2", 90'(bus.out_tag), 90'(2));

        // Frame 3: in_last on beat 4 is a short frame
        for (int k = 0; k < 5; k++) send_beat(6'(k + 20), k == 4);
        check("err_pulse", 90'(bus.err_frame), 90'(1));
        check("err_busy", 90'(bus.busy), 90'(0));
        check("err_ready", 90'(bus.in_ready), 90'(1));
        step();
        check("err_clear", 90'(bus.err_frame), 90'(0));
        repeat (6) step();
        check("err_no_launch", 90'(launch_cnt), 90'(2));
        check("err_count", 90'(err_cnt), 90'(1));
        check("err_no_valid", 90'(bus.out_valid), 90'(0));

        // Frame 4: clean frame restarts at k=0; 6'h3F at k=0 gives a0=F
        bus.core_y = y3;
        send_beat(6'h3F, 1'b0);
        for (int k = 1; k < 12; k++) send_beat(6'(k + 1), k == 11);
        exp_ops = {4'hF, 5'd2, 6'd3, 4'd4, 5'd5, 6'd6, 4'd7, 5'd8, 6'd9, 4'd10, 5'd11, 6'd12};
        check("ops_after_err", 90'(bus.core_ops), 90'(exp_ops));
        check("launch_after_err", 90'(bus.core_launch), 90'(1));
        drain_all(y3, 4'd2);
        check("tag_after_4", 90'(bus.out_tag), 90'(3));
        check("err_count_4", 90'(err_cnt), 90'(1));

        // Frame 5: reset during DRAIN after chunk 2
        bus.core_y = y1;
        for (int k = 0; k < 12; k++) send_beat(6'h3F, 1'b0);
        bus.out_ready = 1'b1;
        n = 0;
        while (!bus.out_valid && n < 200) begin
            step();
            n++;
        end
        step();
        step();
        bus.out_ready = 1'b0;
        check("pre_rst_chunk3", 90'(bus.out_data), 90'(3));
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_outs", 90'({bus.in_ready, bus.out_valid, bus.out_data, bus.out_last,
                                  bus.out_tag, bus.busy, bus.err_frame, bus.core_launch}), 90'(0));
        check("midrst_core_ops", 90'(bus.core_ops), 90'(0));
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("ready_after_rst", 90'(bus.in_ready), 90'(1));
        for (int k = 0; k < 12; k++) send_beat(6'(k + 1), 1'b0);
        drain_all(y1, 4'd0);
        check("tag_after_rst", 90'(bus.out_tag), 90'(1));
        check("err_count_final", 90'(err_cnt), 90'(1));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
